fft8_input_loader: RTL
======================

# fft8_input_loader

Serial-to-parallel input stage for the 8-point FFT datapath. Accepts one complex sample per handshake and assembles frames of 8 samples. Presents each completed frame on a parallel bus in bit-reversed order (0,4,2,6,1,5,3,7), so the radix-2 butterfly stages can be wired without crossings. Holds the frame until the downstream FFT core accepts it.

## Interface
- N, default 4: word width is 2**N bits, two's complement, matching the butterfly stages.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present on in_r/in_i.
- in_ready  out  1  loader can accept a sample this cycle.
- in_sof  in  1  start-of-frame marker; qualified by in_valid && in_ready.
- in_r, in_i  in  2**N each  real/imag input sample.
- out_valid  out  1  a complete frame is presented.
- out_ready  in  1  downstream accepts the frame.
- out_r, out_i  out  8*2**N each  slot k at [k*2**N +: 2**N]; slot k holds input sample bitrev3(k).
- err_sof  out  1  one-cycle pulse when in_sof truncates a partial frame.

## Operation
- Input accept = in_valid && in_ready. Output accept = out_valid && out_ready.
- Write counter wr_idx (3 bit) selects the storage slot. Sample index j is written directly into slot bitrev3(j): j=1→slot 4, j=3→slot 6, and so on.
- wr_idx increments on each accept and wraps 7→0. The accept at wr_idx=7 marks the bank FULL.
- in_sof accepted with wr_idx≠0:
  - the partial frame is discarded;
  - the sample is written as index 0 and wr_idx becomes 1;
  - err_sof pulses for one cycle.
- in_sof at wr_idx=0 is normal. in_sof is never required; without it, frames are every 8 accepts.
- Bank states: FILLING → FULL on the 8th accept. FULL → FILLING on output accept of that bank.
- out_valid = the read bank is FULL. out_r/out_i are driven from the read-bank registers and are stable while out_valid && !out_ready.
- in_ready = the write bank is FILLING. in_ready never depends combinationally on out_ready.
- The stage does no arithmetic: samples pass bit-exact and are not scaled.

## Timing
- Reset (rst=1 at a clock edge), effective the next cycle:
  - wr_idx=0; all banks FILLING; storage=0;
  - out_valid=0, out_r=out_i=0, err_sof=0;
  - in_ready=1 from the first cycle after reset.
- Latency: out_valid rises the cycle after the 8th sample's accept edge. Minimum input-to-output latency is 1 cycle after the last sample.
- Reset mid-frame or mid-hold drops all data. No output accept is reported for dropped data.
- Simultaneous 8th input accept and output accept (double-buffer build):
  - both take effect;
  - the just-read bank returns to FILLING;
  - the newly filled bank becomes the read bank next cycle;
  - out_valid stays 1 with new data.
- Throughput: double-buffer build sustains one sample per cycle with out_ready held at 1.

## Configuration
- FFT8_LOADER_DOUBLE_BUF_EN defined:
  - two banks, ping-pong; write-bank and read-bank selectors toggle independently;
  - in_ready is low only when both banks are FULL.
- Undefined:
  - single bank;
  - in_ready=0 from the cycle after the 8th accept until the cycle after the output accept;
  - one dead cycle per frame minimum.

## Structure
- Package fft8_pkg:
  - FFT_POINTS=8 and FFT_LOG2=3;
  - the bitrev3 function;
  - the bank-state encoding (FILLING=0, FULL=1).
- Sub-module fft8_sample_bank holds one 8×complex register bank. It has:
  - a write port (enable, slot address, data);
  - a flat read-out of all 8 slots;
  - a full flag with set/clear inputs.
- The top instantiates one bank, or two under the macro, plus the counters and the handshake logic.

## Test plan
- Reset then feed samples r=j+1, i=-(j+1) for j=0..7, one per cycle, out_ready=1:
  - out_valid rises 1 cycle after the 8th sample;
  - out_r slots = 1,5,3,7,2,6,4,8;
  - out_valid falls the next cycle (single-buffer build).
- Hold out_ready=0 with a frame presented and keep feeding:
  - outputs stay stable;
  - double-buffer build: in_ready falls after a second 8 samples;
  - single-buffer build: in_ready falls immediately.
- in_sof asserted at wr_idx=5 with sample r=0x7FFF:
  - err_sof pulses once;
  - the next completed frame has slot 0 = 0x7FFF and is completed after 7 more samples.
- Continuous stream of 32 samples, out_ready=1, double-buffer build:
  - in_ready constantly 1;
  - 4 frames emitted, each in order;
  - no sample lost or duplicated.
- Assert rst after 3 samples, then send 8 fresh samples:
  - exactly one frame appears, containing only the fresh samples;
  - all outputs are 0 during reset.
- Random in_valid and out_ready over 10,000 cycles, checked against a scoreboard: every frame matches bit-reversed input order, and no frame is lost.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared constants, bit-reversal helper and bank-state encoding for the fft8 input loader.
// Latency: none (package only).
// Backpressure: none (package only).
package fft8_pkg;

   localparam int FFT_POINTS = 8;
   localparam int FFT_LOG2   = 3;

   typedef enum logic {
      BANK_FILLING = 1'b0,
      BANK_FULL    = 1'b1
   } bank_state_t;

   // Sample index j lands in slot bitrev3(j), so slot k holds sample bitrev3(k).
   function automatic logic [FFT_LOG2-1:0] bitrev3(input logic [FFT_LOG2-1:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

endpackage

// File: rtl/fft8_sample_bank.sv
// One 8-slot complex register bank with a write port, a flat read-out and a full flag.
// Latency: a write is visible on rd_r/rd_i the cycle after wr_en.
// Backpressure: none here; the owner must not write while the bank is FULL.
module fft8_sample_bank
   import fft8_pkg::*;
#(
   parameter int W = 16
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [FFT_LOG2-1:0]        wr_slot,
   input  logic [W-1:0]               wr_r,
   input  logic [W-1:0]               wr_i,
   input  logic                       set_full,
   input  logic                       clr_full,
   output bank_state_t                state,
   output logic [FFT_POINTS*W-1:0]    rd_r,
   output logic [FFT_POINTS*W-1:0]    rd_i
);

   logic [W-1:0] mem_r [FFT_POINTS];
   logic [W-1:0] mem_i [FFT_POINTS];

   // Sample storage: cleared on reset, one slot written per accepted sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < FFT_POINTS; k++) begin
            mem_r[k] <= '0;
            mem_i[k] <= '0;
         end
      end else if (wr_en) begin
         mem_r[wr_slot] <= wr_r;
         mem_i[wr_slot] <= wr_i;
      end
   end

   // Full flag: set when the last sample of a frame lands, cleared when the frame is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BANK_FILLING;
      end else if (set_full) begin
         state <= BANK_FULL;
      end else if (clr_full) begin
         state <= BANK_FILLING;
      end
   end

   // Flatten the slots onto the parallel bus, slot k at [k*W +: W].
   always_comb begin
      rd_r = '0;
      rd_i = '0;
      for (int k = 0; k < FFT_POINTS; k++) begin
         rd_r[k*W +: W] = mem_r[k];
         rd_i[k*W +: W] = mem_i[k];
      end
   end

endmodule

// File: rtl/fft8_input_loader.sv
// Serial-to-parallel loader: assembles 8 complex samples into a bit-reversed parallel frame.
// Latency: out_valid rises the cycle after the 8th sample is accepted.
// Backpressure: in_ready drops while no bank is free; the frame is held until out_ready.
// Build option FFT8_LOADER_DOUBLE_BUF_EN: two ping-pong banks instead of one.
module fft8_input_loader
   import fft8_pkg::*;
#(
   parameter int N = 4
)
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_sof,
   input  logic [(1<<N)-1:0]                 in_r,
   input  logic [(1<<N)-1:0]                 in_i,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [FFT_POINTS*(1<<N)-1:0]      out_r,
   output logic [FFT_POINTS*(1<<N)-1:0]      out_i,
   output logic                              err_sof
);

   localparam int W = 1 << N;

   logic [FFT_LOG2-1:0] wr_idx;
   logic [FFT_LOG2-1:0] eff_idx;
   logic [FFT_LOG2-1:0] wr_slot;
   logic                in_acc;
   logic                out_acc;
   logic                sof_trunc;
   logic                last_acc;

   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid && out_ready;
   // A start-of-frame always restarts at index 0; any partial frame is simply overwritten.
   assign eff_idx   = in_sof ? '0 : wr_idx;
   assign wr_slot   = bitrev3(eff_idx);
   assign sof_trunc = in_acc && in_sof && (wr_idx != '0);
   assign last_acc  = in_acc && (eff_idx == 3'(FFT_POINTS-1));

   // Write counter: advances per accepted sample and wraps 7 -> 0 at frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
      end else if (in_acc) begin
         wr_idx <= eff_idx + 1'b1;
      end
   end

   // One-cycle error pulse when a start-of-frame cuts a partial frame short.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sof <= 1'b0;
      end else begin
         err_sof <= sof_trunc;
      end
   end

`ifdef FFT8_LOADER_DOUBLE_BUF_EN
   logic                       wr_sel;
   logic                       rd_sel;
   bank_state_t                st0;
   bank_state_t                st1;
   logic [FFT_POINTS*W-1:0]    r0;
   logic [FFT_POINTS*W-1:0]    i0;
   logic [FFT_POINTS*W-1:0]    r1;
   logic [FFT_POINTS*W-1:0]    i1;

   // Ping-pong selectors: write side flips on frame completion, read side on frame hand-off.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
      end else begin
         if (last_acc) wr_sel <= ~wr_sel;
         if (out_acc)  rd_sel <= ~rd_sel;
      end
   end

   fft8_sample_bank #(.W(W)) u_bank0 (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (in_acc && !wr_sel),
      .wr_slot  (wr_slot),
      .wr_r     (in_r),
      .wr_i     (in_i),
      .set_full (last_acc && !wr_sel),
      .clr_full (out_acc && !rd_sel),
      .state    (st0),
      .rd_r     (r0),
      .rd_i     (i0)
   );

   fft8_sample_bank #(.W(W)) u_bank1 (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (in_acc && wr_sel),
      .wr_slot  (wr_slot),
      .wr_r     (in_r),
      .wr_i     (in_i),
      .set_full (last_acc && wr_sel),
      .clr_full (out_acc && rd_sel),
      .state    (st1),
      .rd_r     (r1),
      .rd_i     (i1)
   );

   // Banks fill and drain in order, so the write bank is FULL only when both are.
   assign in_ready  = ((wr_sel ? st1 : st0) == BANK_FILLING);
   assign out_valid = ((rd_sel ? st1 : st0) == BANK_FULL);
   assign out_r     = rd_sel ? r1 : r0;
   assign out_i     = rd_sel ? i1 : i0;
`else
   bank_state_t                st0;
   logic [FFT_POINTS*W-1:0]    r0;
   logic [FFT_POINTS*W-1:0]    i0;

   fft8_sample_bank #(.W(W)) u_bank0 (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (in_acc),
      .wr_slot  (wr_slot),
      .wr_r     (in_r),
      .wr_i     (in_i),
      .set_full (last_acc),
      .clr_full (out_acc),
      .state    (st0),
      .rd_r     (r0),
      .rd_i     (i0)
   );

   // Single bank: input stalls from frame completion until the frame is taken.
   assign in_ready  = (st0 == BANK_FILLING);
   assign out_valid = (st0 == BANK_FULL);
   assign out_r     = r0;
   assign out_i     = i0;
`endif

endmodule
